// File: rtl/fnv1a_digest_checker_if.sv
// Handshake bundle for the FNV-1a digest checker: expected-digest channel,
// payload byte stream, abort strobe and result channel.
interface fnv1a_digest_checker_if #(parameter int LEN_W = 8);
  logic             exp_valid;
  logic [31:0]      exp_data;
  logic             exp_ready;
  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_last;
  logic             s_ready;
  logic             abort;
  logic             res_valid;
  logic             res_ready;
  logic             res_match;
  logic             res_ovf;
  logic [31:0]      res_digest;
  logic [LEN_W-1:0] res_len;

  modport master (
    output exp_valid, exp_data, s_valid, s_data, s_last, abort, res_ready,
    input  exp_ready, s_ready, res_valid, res_match, res_ovf, res_digest, res_len
  );

  modport slave (
    input  exp_valid, exp_data, s_valid, s_data, s_last, abort, res_ready,
    output exp_ready, s_ready, res_valid, res_match, res_ovf, res_digest, res_len
  );
endinterface

// File: rtl/fnv1a_digest_checker.sv
// Receive-side FNV-1a 32 checker: latches an expected digest, hashes one byte
// per cycle and reports match / overflow / digest / length.
//
//   state  | meaning
//   IDLE   | waiting for an expected digest (exp_ready=1)
//   HASH   | absorbing payload bytes (s_ready=1)
//   RESULT | result presented until res_ready or abort
module fnv1a_digest_checker #(
  parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
  parameter logic [31:0] FNV_PRIME    = 32'h01000193,
  parameter int          MAX_LEN      = 255
) (
  input logic                    clk,
  input logic                    rst_n,
  fnv1a_digest_checker_if.slave  bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, HASH, RESULT} state_t;

  state_t             state, next_state;
  logic [31:0]        hash, expected, mix, hash_next;
  logic [LEN_W-1:0]   len, len_next;
  logic               match_q, ovf_q;
  logic               exp_take, byte_take, hit_max;

  assign exp_take  = (state == IDLE) && bus.exp_valid;
  assign byte_take = (state == HASH) && bus.s_valid && !bus.abort;
  assign len_next  = len + LEN_W'(1);
  assign hit_max   = (len_next == LEN_W'(MAX_LEN));

  // Constant multiply unrolled into shifted adds of the set prime bits.
  always_comb begin
    mix       = hash ^ {24'b0, bus.s_data};
    hash_next = '0;
    for (int i = 0; i < 32; i++) begin
      if (FNV_PRIME[i]) hash_next = hash_next + (mix << i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.exp_valid) next_state = HASH;
      HASH: begin
        if (bus.abort) next_state = IDLE;
        else if (byte_take && (bus.s_last || hit_max)) next_state = RESULT;
      end
      RESULT: begin
        if (bus.abort || bus.res_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash     <= OFFSET_BASIS;
      expected <= '0;
      len      <= '0;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (exp_take) begin
      hash     <= OFFSET_BASIS;
      expected <= bus.exp_data;
      len      <= '0;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (byte_take) begin
      hash <= hash_next;
      len  <= len_next;
      if (bus.s_last) begin
        match_q <= (hash_next == expected);
        ovf_q   <= 1'b0;
      end else if (hit_max) begin
        match_q <= 1'b0;
        ovf_q   <= 1'b1;
      end
    end
  end

  // Result fields are masked outside RESULT so an abort leaves them cleared.
  always_comb begin
    bus.exp_ready  = (state == IDLE);
    bus.s_ready    = (state == HASH);
    bus.res_valid  = (state == RESULT);
    bus.res_match  = (state == RESULT) && match_q;
    bus.res_ovf    = (state == RESULT) && ovf_q;
    bus.res_digest = (state == RESULT) ? hash : '0;
    bus.res_len    = (state == RESULT) ? len : '0;
  end
endmodule

// File: tb/tb_fnv1a_digest_checker.sv
// Self-checking bench for fnv1a_digest_checker against a plain-arithmetic
// FNV-1a reference; a second instance uses MAX_LEN=4 for the overflow case.
module tb_fnv1a_digest_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  logic [7:0] msg[$];

  fnv1a_digest_checker_if #(.LEN_W(8)) if_a();
  fnv1a_digest_checker_if #(.LEN_W(3)) if_b();

  fnv1a_digest_checker #(.MAX_LEN(255)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  fnv1a_digest_checker #(.MAX_LEN(4))   dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_fnv();
    logic [31:0] h;
    h = 32'h811C9DC5;
    foreach (msg[i]) h = (h ^ {24'b0, msg[i]}) * 32'h01000193;
    return h;
  endfunction

  task automatic load_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  task automatic start_a(input logic [31:0] e);
    @(negedge clk);
    if_a.exp_valid = 1'b1;
    if_a.exp_data  = e;
    @(negedge clk);
    if_a.exp_valid = 1'b0;
  endtask

  task automatic send_a(input int gap_max, input bit with_last);
    foreach (msg[i]) begin
      if (gap_max > 0) begin
        if_a.s_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
      if_a.s_valid = 1'b1;
      if_a.s_data  = msg[i];
      if_a.s_last  = with_last && (i == msg.size() - 1);
      @(negedge clk);
    end
    if_a.s_valid = 1'b0;
    if_a.s_last  = 1'b0;
  endtask

  task automatic release_a();
    if_a.res_ready = 1'b1;
    @(negedge clk);
    if_a.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    {if_a.exp_valid, if_a.s_valid, if_a.s_last, if_a.abort, if_a.res_ready} = '0;
    {if_b.exp_valid, if_b.s_valid, if_b.s_last, if_b.abort, if_b.res_ready} = '0;
    if_a.exp_data = '0; if_a.s_data = '0; if_b.exp_data = '0; if_b.s_data = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (if_a.exp_ready !== 1'b1) $display("FAIL rst_exp_ready got=%b exp=1", if_a.exp_ready); else passed++;
    total++; if (if_a.s_ready !== 1'b0) $display("FAIL rst_s_ready got=%b exp=0", if_a.s_ready); else passed++;
    total++; if (if_a.res_valid !== 1'b0) $display("FAIL rst_res_valid got=%b exp=0", if_a.res_valid); else passed++;
    total++; if ({if_a.res_match, if_a.res_ovf} !== 2'b00) $display("FAIL rst_match_ovf got=%b exp=00", {if_a.res_match, if_a.res_ovf}); else passed++;
    total++; if (if_a.res_digest !== 32'h0) $display("FAIL rst_digest got=%h exp=0", if_a.res_digest); else passed++;
    total++; if (if_a.res_len !== 8'd0) $display("FAIL rst_len got=%0d exp=0", if_a.res_len); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (if_a.exp_ready !== 1'b1) $display("FAIL post_rst_idle got=%b exp=1", if_a.exp_ready); else passed++;
  endtask

  task automatic test_single();
    load_str("a");
    start_a(32'hE40C292C);
    send_a(0, 1'b1);
    total++; if (if_a.res_valid !== 1'b1) $display("FAIL single_latency res_valid got=%b exp=1", if_a.res_valid); else passed++;
    total++; if (if_a.res_match !== 1'b1) $display("FAIL single_match got=%b exp=1", if_a.res_match); else passed++;
    total++; if (if_a.res_ovf !== 1'b0) $display("FAIL single_ovf got=%b exp=0", if_a.res_ovf); else passed++;
    total++; if (if_a.res_digest !== 32'hE40C292C) $display("FAIL single_digest got=%h exp=e40c292c", if_a.res_digest); else passed++;
    total++; if (if_a.res_len !== 8'd1) $display("FAIL single_len got=%0d exp=1", if_a.res_len); else passed++;
    release_a();
    total++; if ({if_a.res_valid, if_a.exp_ready} !== 2'b01) $display("FAIL single_release got=%b exp=01", {if_a.res_valid, if_a.exp_ready}); else passed++;
  endtask

  task automatic test_back_to_back();
    load_str("foobar");
    start_a(32'hBF9CF968);
    send_a(0, 1'b1);
    total++; if (if_a.res_valid !== 1'b1) $display("FAIL b2b_valid got=%b exp=1", if_a.res_valid); else passed++;
    total++; if (if_a.res_match !== 1'b1) $display("FAIL b2b_match got=%b exp=1", if_a.res_match); else passed++;
    total++; if (if_a.res_digest !== 32'hBF9CF968) $display("FAIL b2b_digest got=%h exp=bf9cf968", if_a.res_digest); else passed++;
    total++; if (if_a.res_len !== 8'd6) $display("FAIL b2b_len got=%0d exp=6", if_a.res_len); else passed++;
    release_a();
  endtask

  task automatic test_gaps_and_hold();
    logic [31:0] d;
    load_str("foobar");
    d = ref_fnv();
    start_a(32'hBF9CF969);
    send_a(3, 1'b1);
    total++; if (if_a.res_match !== 1'b0) $display("FAIL gaps_match got=%b exp=0", if_a.res_match); else passed++;
    total++; if (if_a.res_digest !== d) $display("FAIL gaps_digest got=%h exp=%h", if_a.res_digest, d); else passed++;
    total++; if (if_a.res_len !== 8'd6) $display("FAIL gaps_len got=%0d exp=6", if_a.res_len); else passed++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if ({if_a.res_valid, if_a.res_match, if_a.res_ovf} !== 3'b100) $display("FAIL hold_flags cyc=%0d got=%b exp=100", c, {if_a.res_valid, if_a.res_match, if_a.res_ovf}); else passed++;
      total++; if (if_a.res_digest !== d || if_a.res_len !== 8'd6) $display("FAIL hold_data cyc=%0d got=%h/%0d exp=%h/6", c, if_a.res_digest, if_a.res_len, d); else passed++;
    end
    release_a();
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    int n;
    bit good;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 24);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      d = ref_fnv();
      good = 1'($urandom);
      e = good ? d : (d ^ (32'h1 << $urandom_range(0, 31)));
      start_a(e);
      send_a(2, 1'b1);
      total++; if (if_a.res_valid !== 1'b1 || if_a.res_match !== good) $display("FAIL rand%0d_match got=%b/%b exp=1/%b", k, if_a.res_valid, if_a.res_match, good); else passed++;
      total++; if (if_a.res_digest !== d) $display("FAIL rand%0d_digest got=%h exp=%h", k, if_a.res_digest, d); else passed++;
      total++; if (if_a.res_len !== 8'(n)) $display("FAIL rand%0d_len got=%0d exp=%0d", k, if_a.res_len, n); else passed++;
      release_a();
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0] b5;
    msg.delete();
    for (int i = 0; i < 255; i++) msg.push_back(8'($urandom));
    d = ref_fnv();
    start_a(d);
    send_a(0, 1'b0);
    total++; if ({if_a.res_valid, if_a.res_ovf, if_a.res_match} !== 3'b110) $display("FAIL max255_flags got=%b exp=110", {if_a.res_valid, if_a.res_ovf, if_a.res_match}); else passed++;
    total++; if (if_a.res_len !== 8'd255 || if_a.res_digest !== d) $display("FAIL max255_data got=%0d/%h exp=255/%h", if_a.res_len, if_a.res_digest, d); else passed++;
    total++; if (if_a.s_ready !== 1'b0) $display("FAIL max255_s_ready got=%b exp=0", if_a.s_ready); else passed++;
    release_a();

    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back(8'($urandom));
    b5 = msg[4];
    void'(msg.pop_back());
    d = ref_fnv();
    @(negedge clk);
    if_b.exp_valid = 1'b1;
    if_b.exp_data  = d;
    @(negedge clk);
    if_b.exp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if_b.s_valid = 1'b1;
      if_b.s_data  = msg[i];
      @(negedge clk);
    end
    total++; if ({if_b.res_valid, if_b.res_ovf, if_b.res_match} !== 3'b110) $display("FAIL ovf4_flags got=%b exp=110", {if_b.res_valid, if_b.res_ovf, if_b.res_match}); else passed++;
    total++; if (if_b.res_len !== 3'd4 || if_b.res_digest !== d) $display("FAIL ovf4_data got=%0d/%h exp=4/%h", if_b.res_len, if_b.res_digest, d); else passed++;
    if_b.s_data = b5;
    total++; if (if_b.s_ready !== 1'b0) $display("FAIL ovf4_fifth_ready got=%b exp=0", if_b.s_ready); else passed++;
    @(negedge clk);
    total++; if (if_b.res_len !== 3'd4 || if_b.res_digest !== d) $display("FAIL ovf4_stable got=%0d/%h exp=4/%h", if_b.res_len, if_b.res_digest, d); else passed++;
    if_b.res_ready = 1'b1;
    @(negedge clk);
    if_b.res_ready = 1'b0;
    if_b.s_valid   = 1'b0;
    total++; if ({if_b.res_valid, if_b.exp_ready} !== 2'b01) $display("FAIL ovf4_release got=%b exp=01", {if_b.res_valid, if_b.exp_ready}); else passed++;
  endtask

  task automatic test_abort();
    load_str("foo");
    start_a(32'hBF9CF968);
    send_a(0, 1'b0);
    if_a.abort = 1'b1; if_a.s_valid = 1'b1; if_a.s_data = 8'h62; if_a.s_last = 1'b1;
    @(negedge clk);
    if_a.abort = 1'b0; if_a.s_valid = 1'b0; if_a.s_last = 1'b0;
    total++; if ({if_a.exp_ready, if_a.s_ready, if_a.res_valid} !== 3'b100) $display("FAIL abort_hash got=%b exp=100", {if_a.exp_ready, if_a.s_ready, if_a.res_valid}); else passed++;
    // abort is ignored in IDLE: the digest offer must still be taken
    load_str("a");
    if_a.abort = 1'b1; if_a.exp_valid = 1'b1; if_a.exp_data = 32'hE40C292C;
    @(negedge clk);
    if_a.abort = 1'b0; if_a.exp_valid = 1'b0;
    total++; if (if_a.s_ready !== 1'b1) $display("FAIL abort_idle_ignored got=%b exp=1", if_a.s_ready); else passed++;
    send_a(0, 1'b1);
    total++; if ({if_a.res_valid, if_a.res_match} !== 2'b11) $display("FAIL abort_reseed_match got=%b exp=11", {if_a.res_valid, if_a.res_match}); else passed++;
    total++; if (if_a.res_digest !== 32'hE40C292C || if_a.res_len !== 8'd1) $display("FAIL abort_reseed_data got=%h/%0d exp=e40c292c/1", if_a.res_digest, if_a.res_len); else passed++;
    if_a.abort = 1'b1;
    @(negedge clk);
    if_a.abort = 1'b0;
    total++; if ({if_a.res_valid, if_a.exp_ready, if_a.res_match} !== 3'b010) $display("FAIL abort_result got=%b exp=010", {if_a.res_valid, if_a.exp_ready, if_a.res_match}); else passed++;
    total++; if (if_a.res_digest !== 32'h0 || if_a.res_len !== 8'd0) $display("FAIL abort_result_cleared got=%h/%0d exp=0/0", if_a.res_digest, if_a.res_len); else passed++;
  endtask

  task automatic test_reset_mid_hash();
    load_str("fo");
    start_a(32'hBF9CF968);
    send_a(0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({if_a.exp_ready, if_a.s_ready, if_a.res_valid} !== 3'b100) $display("FAIL midrst_state got=%b exp=100", {if_a.exp_ready, if_a.s_ready, if_a.res_valid}); else passed++;
    total++; if (if_a.res_digest !== 32'h0 || if_a.res_len !== 8'd0) $display("FAIL midrst_outputs got=%h/%0d exp=0/0", if_a.res_digest, if_a.res_len); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    load_str("a");
    start_a(32'hE40C292C);
    send_a(1, 1'b1);
    total++; if ({if_a.res_valid, if_a.res_match} !== 2'b11 || if_a.res_len !== 8'd1) $display("FAIL midrst_reseed got=%b/%0d exp=11/1", {if_a.res_valid, if_a.res_match}, if_a.res_len); else passed++;
    release_a();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps_and_hold();
    test_random();
    test_overflow();
    test_abort();
    test_reset_mid_hash();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
